carry8_pipe_adder: RTL and testbench

Pipelined wide adder/subtractor that drives a chain of `CARRY8` slices, one 8-bit slice per pipeline stage, with the inter-slice carry registered between stages. It is the operand-preparation and carry-pipelining stage directly upstream of `CARRY8`. It generates each slice's `S` (propagate) and `DI` (generate) vectors, feeds them to its `CARRY8` instance, and consumes the `O`/`CO` outputs into skew and deskew registers. The result is a wide sum that closes timing at any width.

---
 rtl/carry8_pipe_adder.sv | 186 ++++++++++++++++++
 tb/tb_carry8_pipe_adder.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/carry8_pipe_adder.sv
// Pipelined W-bit adder/subtractor built from a chain of CARRY8 slices, one slice per
// stage, with the inter-slice carry registered and operands/results skewed to match.

module carry8_pipe_adder #(
    parameter int N_SLICES = 4
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  CE,
    input  logic                  IN_VLD,
    input  logic [8*N_SLICES-1:0] A,
    input  logic [8*N_SLICES-1:0] B,
    input  logic                  CI,
    input  logic                  SUB,
    output logic                  OUT_VLD,
    output logic [8*N_SLICES-1:0] SUM,
    output logic                  CO,
    output logic                  OV
);
    localparam int W = 8 * N_SLICES;

    logic [W-1:0]        a_op;
    logic [W-1:0]        b_op;
    logic                cie_op;
    logic [N_SLICES:0]   vld;
    logic [N_SLICES-1:0] c_q;
    logic                ov_q;

    // B is inverted here so every stage below is a plain adder.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            a_op   <= '0;
            b_op   <= '0;
            cie_op <= 1'b0;
        end else if (CE && IN_VLD) begin
            a_op   <= A;
            b_op   <= B ^ {W{SUB}};
            cie_op <= SUB | CI;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            vld <= '0;
        end else if (CE) begin
            vld <= {vld[N_SLICES-1:0], IN_VLD};
        end
    end

    for (genvar k = 0; k < N_SLICES; k++) begin : g_slice
        logic [7:0] a_s;
        logic [7:0] b_s;
        logic [7:0] o_w;
        logic [7:0] co_w;
        logic [7:0] r_q;
        logic [7:0] res;
        logic       c_in;
        logic       c_r;
        logic       unused_co;

        if (k == 0) begin : g_noskew
            assign a_s  = a_op[7:0];
            assign b_s  = b_op[7:0];
            assign c_in = cie_op;
        end else begin : g_skew
            logic [7:0] a_sr [k];
            logic [7:0] b_sr [k];

            always_ff @(posedge CLK or negedge RSTN) begin
                if (!RSTN) begin
                    for (int i = 0; i < k; i++) begin
                        a_sr[i] <= '0;
                        b_sr[i] <= '0;
                    end
                end else if (CE) begin
                    a_sr[0] <= a_op[8*k +: 8];
                    b_sr[0] <= b_op[8*k +: 8];
                    for (int i = 1; i < k; i++) begin
                        a_sr[i] <= a_sr[i-1];
                        b_sr[i] <= b_sr[i-1];
                    end
                end
            end

            assign a_s  = a_sr[k-1];
            assign b_s  = b_sr[k-1];
            assign c_in = c_q[k-1];
        end

        CARRY8 #(
            .CARRY_TYPE ("SINGLE_CY8")
        ) u_carry8 (
            .CI     (c_in),
            .CI_TOP (1'b0),
            .DI     (a_s),
            .S      (a_s ^ b_s),
            .O      (o_w),
            .CO     (co_w)
        );

        always_ff @(posedge CLK or negedge RSTN) begin
            if (!RSTN) begin
                r_q <= '0;
                c_r <= 1'b0;
            end else if (CE) begin
                r_q <= o_w;
                c_r <= co_w[7];
            end
        end

        assign c_q[k]    = c_r;
        assign unused_co = ^co_w[6:0];

        if (k == N_SLICES - 1) begin : g_nodeskew
            assign res = r_q;

            // Carry into the MSB XOR carry out of the MSB, captured with the last carry.
            always_ff @(posedge CLK or negedge RSTN) begin
                if (!RSTN) begin
                    ov_q <= 1'b0;
                end else if (CE) begin
                    ov_q <= co_w[6] ^ co_w[7];
                end
            end
        end else begin : g_deskew
            logic [7:0] d_sr [N_SLICES-1-k];

            always_ff @(posedge CLK or negedge RSTN) begin
                if (!RSTN) begin
                    for (int i = 0; i < N_SLICES - 1 - k; i++) begin
                        d_sr[i] <= '0;
                    end
                end else if (CE) begin
                    d_sr[0] <= r_q;
                    for (int i = 1; i < N_SLICES - 1 - k; i++) begin
                        d_sr[i] <= d_sr[i-1];
                    end
                end
            end

            assign res = d_sr[N_SLICES-2-k];
        end

        assign SUM[8*k +: 8] = res;
    end

    assign OUT_VLD = vld[N_SLICES];
    assign CO      = c_q[N_SLICES-1];
    assign OV      = ov_q;

endmodule

// Behavioural CARRY8: 8-bit carry chain with per-bit propagate S and generate DI.
// DUAL_CY8 splits the chain into two 4-bit halves, the upper one fed from CI_TOP.
module CARRY8 #(
    parameter string CARRY_TYPE = "SINGLE_CY8"
) (
    input  logic       CI,
    input  logic       CI_TOP,
    input  logic [7:0] DI,
    input  logic [7:0] S,
    output logic [7:0] O,
    output logic [7:0] CO
);
    localparam bit DUAL = (CARRY_TYPE == "DUAL_CY8");

    logic unused_top;

    always_comb begin
        logic c;
        c  = CI;
        O  = '0;
        CO = '0;
        for (int i = 0; i < 8; i++) begin
            if (i == 4 && DUAL) begin
                c = CI_TOP;
            end
            O[i]  = S[i] ^ c;
            c     = S[i] ? c : DI[i];
            CO[i] = c;
        end
    end

    assign unused_top = CI_TOP;

endmodule

// File: tb/tb_carry8_pipe_adder.sv
// Bench for carry8_pipe_adder: directed corner cases, stalls, resets and a randomized
// stream, all checked against a transaction-level delay-line model of the adder.

module tb_carry8_pipe_adder;
    localparam int N = 4;
    localparam int W = 8 * N;

    logic         CLK    = 1'b0;
    logic         RSTN   = 1'b1;
    logic         CE     = 1'b1;
    logic         IN_VLD = 1'b0;
    logic         CI     = 1'b0;
    logic         SUB    = 1'b0;
    logic [W-1:0] A      = '0;
    logic [W-1:0] B      = '0;
    logic         OUT_VLD;
    logic [W-1:0] SUM;
    logic         CO;
    logic         OV;

    int n_tests  = 0;
    int n_fail   = 0;
    int accepted = 0;
    int consumed = 0;
    int seen     = 0;

    typedef struct packed {
        logic         v;
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } res_t;

    res_t pipe[$];
    res_t exp_out;

    carry8_pipe_adder #(.N_SLICES(N)) dut (
        .CLK     (CLK),
        .RSTN    (RSTN),
        .CE      (CE),
        .IN_VLD  (IN_VLD),
        .A       (A),
        .B       (B),
        .CI      (CI),
        .SUB     (SUB),
        .OUT_VLD (OUT_VLD),
        .SUM     (SUM),
        .CO      (CO),
        .OV      (OV)
    );

    always #5 CLK = ~CLK;

    // Two's-complement add/sub in plain arithmetic with one extra bit for the carry.
    function automatic res_t ref_add(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic ci, input logic sub);
        res_t         r;
        logic [W:0]   full;
        logic [W-1:0] bx;
        logic         cie;
        bx   = sub ? ~b : b;
        cie  = sub ? 1'b1 : ci;
        full = {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, cie};
        r.v  = v;
        r.s  = full[W-1:0];
        r.co = full[W];
        r.ov = (a[W-1] == bx[W-1]) && (full[W-1] != a[W-1]);
        return r;
    endfunction

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] w;
        case ($urandom_range(0, 7))
            0:       w = '1;
            1:       w = '0;
            2:       w = {1'b1, {(W-1){1'b0}}};
            3:       w = {1'b0, {(W-1){1'b1}}};
            default: w = $urandom;
        endcase
        return w;
    endfunction

    task automatic model_reset();
        pipe.delete();
        for (int i = 0; i < N; i++) pipe.push_back('0);
        exp_out = '0;
    endtask

    task automatic check_word(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check_bit({tag, ".vld"}, OUT_VLD, exp_out.v);
        if (exp_out.v) begin
            check_word({tag, ".sum"}, SUM, exp_out.s);
            check_bit({tag, ".co"}, CO, exp_out.co);
            check_bit({tag, ".ov"}, OV, exp_out.ov);
        end
    endtask

    // One clock: count handshakes seen at this edge, advance the model, check after the edge.
    task automatic cycle(input string tag);
        if (RSTN && CE && IN_VLD) accepted++;
        if (RSTN && CE && OUT_VLD) consumed++;
        @(posedge CLK);
        if (RSTN && CE) begin
            pipe.push_back(ref_add(IN_VLD, A, B, CI, SUB));
            exp_out = pipe.pop_front();
        end
        #1;
        check_outputs(tag);
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                         input logic sub, input string tag);
        A = a; B = b; CI = ci; SUB = sub; IN_VLD = 1'b1;
        cycle(tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            IN_VLD = 1'b0;
            A      = $urandom;
            B      = $urandom;
            CI     = 1'($urandom_range(0, 1));
            SUB    = 1'($urandom_range(0, 1));
            cycle(tag);
        end
    endtask

    task automatic expect_out(input string tag, input logic [W-1:0] s, input logic co, input logic ov);
        check_bit({tag, ".c_vld"}, OUT_VLD, 1'b1);
        check_word({tag, ".c_sum"}, SUM, s);
        check_bit({tag, ".c_co"}, CO, co);
        check_bit({tag, ".c_ov"}, OV, ov);
    endtask

    initial begin
        model_reset();
        A = $urandom; B = $urandom; CI = 1'b1; SUB = 1'($urandom_range(0, 1)); IN_VLD = 1'b1;
        #1 RSTN = 1'b0;
        #2;
        check_bit("rst_async.vld", OUT_VLD, 1'b0);
        check_word("rst_async.sum", SUM, '0);
        check_bit("rst_async.co", CO, 1'b0);
        check_bit("rst_async.ov", OV, 1'b0);
        cycle("rst_hold");
        cycle("rst_hold");
        RSTN = 1'b1;
        idle(10, "rst_idle");

        issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, "ripple1");
        idle(N, "ripple1");
        expect_out("ripple1", 32'h0000_0000, 1'b1, 1'b0);
        issue(32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, "ripple2");
        idle(N, "ripple2");
        expect_out("ripple2", 32'h8000_0000, 1'b0, 1'b1);

        issue(32'd5, 32'd7, 1'b0, 1'b1, "sub1");
        idle(N, "sub1");
        expect_out("sub1", 32'hFFFF_FFFE, 1'b0, 1'b0);
        issue(32'h8000_0000, 32'd1, 1'b0, 1'b1, "sub2");
        idle(N, "sub2");
        expect_out("sub2", 32'h7FFF_FFFF, 1'b1, 1'b1);
        issue(32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, "sub3");
        idle(N, "sub3");
        expect_out("sub3", 32'h0000_0000, 1'b1, 1'b0);
        issue(32'd10, 32'd3, 1'b1, 1'b1, "sub4");
        idle(N, "sub4");
        expect_out("sub4", 32'd7, 1'b1, 1'b0);

        issue(32'd1, 32'd2, 1'b0, 1'b0, "strm");
        issue(32'h0000_00FF, 32'd1, 1'b0, 1'b0, "strm");
        issue(32'hFFFF_FF00, 32'h0000_0100, 1'b0, 1'b0, "strm");
        idle(N - 2, "strm");
        expect_out("strm0", 32'd3, 1'b0, 1'b0);
        idle(1, "strm");
        expect_out("strm1", 32'h0000_0100, 1'b0, 1'b0);
        idle(1, "strm");
        expect_out("strm2", 32'h0000_0000, 1'b1, 1'b0);
        idle(2, "strm");

        issue(32'h1111_1111, 32'h2222_2222, 1'b1, 1'b0, "stall");
        idle(2, "stall");
        CE = 1'b0;
        idle(2, "stall_ce0");
        CE = 1'b1;
        idle(1, "stall");
        check_bit("stall.early", OUT_VLD, 1'b0);
        idle(1, "stall");
        expect_out("stall", 32'h3333_3334, 1'b0, 1'b0);
        CE = 1'b0;
        idle(2, "stall_hold");
        expect_out("stall_hold", 32'h3333_3334, 1'b0, 1'b0);
        CE = 1'b1;
        idle(1, "stall");
        check_bit("stall.drop", OUT_VLD, 1'b0);
        check_word("stall.count", W'(consumed), W'(accepted));

        issue(32'h8000_0001, 32'h8000_0001, 1'b0, 1'b0, "rstmf_x");
        idle(2, "rstmf");
        issue(32'h0000_1000, 32'h0000_0234, 1'b0, 1'b0, "rstmf_y");
        issue(32'h0000_0009, 32'h0000_0004, 1'b0, 1'b1, "rstmf_z");
        expect_out("rstmf_x", 32'h0000_0002, 1'b1, 1'b1);
        IN_VLD = 1'b0;
        RSTN   = 1'b0;
        #1;
        check_bit("rstmf.vld", OUT_VLD, 1'b0);
        check_word("rstmf.sum", SUM, '0);
        check_bit("rstmf.co", CO, 1'b0);
        check_bit("rstmf.ov", OV, 1'b0);
        model_reset();
        accepted = 0;
        consumed = 0;
        cycle("rstmf_hold");
        RSTN = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            idle(1, "rstmf_after");
            if (OUT_VLD) seen++;
        end
        check_word("rstmf.no_out", W'(seen), '0);

        for (int i = 0; i < 1400; i++) begin
            CE     = ($urandom_range(0, 9) != 0);
            IN_VLD = ($urandom_range(0, 3) != 0);
            A      = rand_word();
            B      = rand_word();
            CI     = 1'($urandom_range(0, 1));
            SUB    = 1'($urandom_range(0, 1));
            cycle("rand");
        end
        CE = 1'b1;
        idle(N + 2, "rand_drain");
        check_word("rand.count", W'(consumed), W'(accepted));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
